branch_target_buffer: RTL and testbench

// Parametrised branch target buffer with a saturating-counter direction predictor for the pipelined MIPS core.

---
 rtl/branch_target_buffer_if.sv | 39 +++
 rtl/branch_target_buffer.sv | 127 ++++++++++++
 tb/tb_branch_target_buffer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_buffer_if
// Purpose  : Fetch-lookup / MEM-update / statistics bundle for the BTB.
// Revision : 1.0
// ============================================================================
interface branch_target_buffer_if #(
   parameter int ENTRIES = 16
);
   localparam int INDEX_W = $clog2(ENTRIES);

   logic               lookup_en;
   logic [31:0]        lookup_pc;
   logic               pred_taken;
   logic [31:0]        pred_target;
   logic [INDEX_W-1:0] pred_index;
   logic               upd_en;
   logic [INDEX_W-1:0] upd_index;
   logic [31:0]        upd_pc;
   logic               upd_taken;
   logic [31:0]        upd_target;
   logic               upd_mispredict;
   logic               flush;
   logic [31:0]        stat_lookups;
   logic [31:0]        stat_mispred;

   modport master (
      output lookup_en, lookup_pc, upd_en, upd_index, upd_pc, upd_taken,
             upd_target, upd_mispredict, flush,
      input  pred_taken, pred_target, pred_index, stat_lookups, stat_mispred
   );

   modport slave (
      input  lookup_en, lookup_pc, upd_en, upd_index, upd_pc, upd_taken,
             upd_target, upd_mispredict, flush,
      output pred_taken, pred_target, pred_index, stat_lookups, stat_mispred
   );
endinterface
`default_nettype wire

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_buffer
// Purpose  : Tagged BTB with saturating-counter direction prediction,
//            bimodal or gshare indexing, flush and performance counters.
// Revision : 1.0
// ============================================================================
module branch_target_buffer #(
   parameter int ENTRIES = 16,
   parameter int CTR_W   = 2,
   parameter int MODE    = 0,
   parameter int GHR_W   = 4
) (
   input  wire logic             CLK,
   input  wire logic             nRST,
   branch_target_buffer_if.slave bus
);
   localparam int INDEX_W = $clog2(ENTRIES);
   localparam int TAG_W   = 30 - INDEX_W;
   localparam logic [CTR_W-1:0] c_CTR_WT  = CTR_W'(1 << (CTR_W - 1));
   localparam logic [CTR_W-1:0] c_CTR_WNT = CTR_W'((1 << (CTR_W - 1)) - 1);
   localparam logic [CTR_W-1:0] c_CTR_MAX = '1;

   logic [ENTRIES-1:0] r_valid;
   logic [CTR_W-1:0]   r_ctr    [ENTRIES];
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [29:0]        r_target [ENTRIES];
   logic [GHR_W-1:0]   r_ghr;
   logic [31:0]        r_statLookups;
   logic [31:0]        r_statMispred;

   logic [INDEX_W-1:0] w_histIdx;
   logic [INDEX_W-1:0] w_lkIdx;
   logic               w_lkHit;
   logic               w_predTaken;
   logic               w_updApply;
   logic               w_updHit;
   logic [CTR_W-1:0]   w_ctrCur;
   logic [CTR_W-1:0]   w_ctrNext;
   logic [GHR_W-1:0]   w_ghrNext;
   logic               w_unused;

   // Lookup reads only registered state, so a same-cycle update is seen next cycle.
   assign w_histIdx   = (MODE == 1) ? INDEX_W'(r_ghr) : '0;
   assign w_lkIdx     = bus.lookup_pc[INDEX_W+1:2] ^ w_histIdx;
   assign w_lkHit     = bus.lookup_en & r_valid[w_lkIdx]
                      & (r_tag[w_lkIdx] == bus.lookup_pc[31:INDEX_W+2]);
   assign w_predTaken = w_lkHit & r_ctr[w_lkIdx][CTR_W-1];

   assign bus.pred_taken   = w_predTaken;
   assign bus.pred_target  = w_predTaken ? {r_target[w_lkIdx], 2'b00}
                                         : bus.lookup_pc + 32'd4;
   assign bus.pred_index   = w_lkIdx;
   assign bus.stat_lookups = r_statLookups;
   assign bus.stat_mispred = r_statMispred;

   assign w_updApply = bus.upd_en & ~bus.flush;
   assign w_updHit   = r_valid[bus.upd_index]
                     & (r_tag[bus.upd_index] == bus.upd_pc[31:INDEX_W+2]);
   assign w_ctrCur   = r_ctr[bus.upd_index];

   always_comb begin
      w_ctrNext = w_ctrCur;
      if (bus.upd_taken && (w_ctrCur != c_CTR_MAX)) begin
         w_ctrNext = w_ctrCur + CTR_W'(1);
      end else if (!bus.upd_taken && (w_ctrCur != '0)) begin
         w_ctrNext = w_ctrCur - CTR_W'(1);
      end
   end

   generate
      if (GHR_W == 1) begin : g_ghrSingle
         assign w_ghrNext = bus.upd_taken;
      end else begin : g_ghrShift
         assign w_ghrNext = {r_ghr[GHR_W-2:0], bus.upd_taken};
      end
   endgenerate

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_valid <= '0;
         r_ghr   <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_ctr[i] <= c_CTR_WNT;
         end
      end else if (bus.flush) begin
         r_valid <= '0;
         r_ghr   <= '0;
      end else if (bus.upd_en) begin
         r_ghr <= w_ghrNext;
         if (w_updHit) begin
            r_ctr[bus.upd_index] <= w_ctrNext;
         end else if (bus.upd_taken) begin
            r_valid[bus.upd_index] <= 1'b1;
            r_ctr[bus.upd_index]   <= c_CTR_WT;
         end
      end
   end

   // Tag and target carry no reset; an invalid entry never exposes them.
   always_ff @(posedge CLK) begin
      if (w_updApply && bus.upd_taken) begin
         r_target[bus.upd_index] <= bus.upd_target[31:2];
         if (!w_updHit) begin
            r_tag[bus.upd_index] <= bus.upd_pc[31:INDEX_W+2];
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_statLookups <= '0;
         r_statMispred <= '0;
      end else begin
         if (bus.lookup_en && (r_statLookups != '1)) begin
            r_statLookups <= r_statLookups + 32'd1;
         end
         if (bus.upd_en && bus.upd_mispredict && (r_statMispred != '1)) begin
            r_statMispred <= r_statMispred + 32'd1;
         end
      end
   end

   assign w_unused = &{1'b0, bus.lookup_pc[1:0], bus.upd_pc[INDEX_W+1:0],
                       bus.upd_target[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_target_buffer
// Purpose  : Directed vector table on a bimodal BTB plus gshare/reset sequences.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_branch_target_buffer;
   logic CLK  = 1'b0;
   logic nRST = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   branch_target_buffer_if #(.ENTRIES(16)) bus0 ();
   branch_target_buffer_if #(.ENTRIES(16)) bus1 ();

   branch_target_buffer #(.ENTRIES(16), .CTR_W(2), .MODE(0), .GHR_W(4)) dut0 (
      .CLK (CLK), .nRST (nRST), .bus (bus0)
   );
   branch_target_buffer #(.ENTRIES(16), .CTR_W(2), .MODE(1), .GHR_W(4)) dut1 (
      .CLK (CLK), .nRST (nRST), .bus (bus1)
   );

   typedef struct {
      logic        lkEn;
      logic [31:0] lkPc;
      logic        upEn;
      logic [31:0] upPc;
      logic        upTk;
      logic [31:0] upTgt;
      logic        upMis;
      logic        fl;
      logic        expTk;
      logic [31:0] expTgt;
      logic [3:0]  expIdx;
      logic [31:0] expLk;
      logic [31:0] expMp;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic idle0();
      bus0.lookup_en = 0; bus0.lookup_pc = 0; bus0.upd_en = 0; bus0.upd_index = 0;
      bus0.upd_pc = 0; bus0.upd_taken = 0; bus0.upd_target = 0;
      bus0.upd_mispredict = 0; bus0.flush = 0;
   endtask

   task automatic idle1();
      bus1.lookup_en = 0; bus1.lookup_pc = 0; bus1.upd_en = 0; bus1.upd_index = 0;
      bus1.upd_pc = 0; bus1.upd_taken = 0; bus1.upd_target = 0;
      bus1.upd_mispredict = 0; bus1.flush = 0;
   endtask

   initial begin
      logic [3:0] ghrExp [4];
      logic       tkSeq  [4];

      // Row: lkEn lkPc upEn upPc upTk upTgt upMis fl | expTk expTgt expIdx expLk expMp
      vecs[0]  = '{1, 32'h040, 0, 32'h000, 0, 32'h000, 0, 0, 0, 32'h044, 4'h0, 0, 0};
      vecs[1]  = '{0, 32'h040, 1, 32'h040, 1, 32'h100, 1, 0, 0, 32'h044, 4'h0, 1, 0};
      vecs[2]  = '{1, 32'h040, 0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h100, 4'h0, 1, 1};
      vecs[3]  = '{1, 32'h040, 1, 32'h040, 0, 32'h000, 1, 0, 1, 32'h100, 4'h0, 2, 1};
      vecs[4]  = '{1, 32'h040, 1, 32'h040, 0, 32'h000, 0, 0, 0, 32'h044, 4'h0, 3, 2};
      vecs[5]  = '{1, 32'h040, 1, 32'h040, 0, 32'h000, 0, 0, 0, 32'h044, 4'h0, 4, 2};
      vecs[6]  = '{1, 32'h040, 1, 32'h040, 1, 32'h100, 0, 0, 0, 32'h044, 4'h0, 5, 2};
      vecs[7]  = '{1, 32'h040, 1, 32'h040, 1, 32'h180, 0, 0, 0, 32'h044, 4'h0, 6, 2};
      vecs[8]  = '{1, 32'h040, 0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h180, 4'h0, 7, 2};
      vecs[9]  = '{1, 32'h440, 1, 32'h440, 1, 32'h200, 1, 0, 0, 32'h444, 4'h0, 8, 2};
      vecs[10] = '{1, 32'h440, 0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h200, 4'h0, 9, 3};
      vecs[11] = '{1, 32'h040, 0, 32'h000, 0, 32'h000, 0, 0, 0, 32'h044, 4'h0, 10, 3};
      vecs[12] = '{1, 32'h07C, 1, 32'h040, 0, 32'h000, 0, 0, 0, 32'h080, 4'hF, 11, 3};
      vecs[13] = '{1, 32'h440, 1, 32'h440, 1, 32'h200, 0, 0, 1, 32'h200, 4'h0, 12, 3};
      vecs[14] = '{0, 32'h1234, 1, 32'h440, 1, 32'h200, 0, 0, 0, 32'h1238, 4'hD, 13, 3};
      vecs[15] = '{1, 32'h440, 1, 32'h440, 0, 32'h000, 0, 0, 1, 32'h200, 4'h0, 13, 3};
      vecs[16] = '{1, 32'h440, 1, 32'h440, 0, 32'h000, 0, 0, 1, 32'h200, 4'h0, 14, 3};
      vecs[17] = '{1, 32'h440, 1, 32'h440, 1, 32'h300, 1, 1, 0, 32'h444, 4'h0, 15, 3};
      vecs[18] = '{1, 32'h440, 1, 32'h440, 1, 32'h300, 0, 0, 0, 32'h444, 4'h0, 16, 4};
      vecs[19] = '{1, 32'h440, 0, 32'h000, 0, 32'h000, 0, 0, 1, 32'h300, 4'h0, 17, 4};

      idle0();
      idle1();
      bus0.lookup_pc = 32'h40;
      #2;
      chk("rst_taken", 32'(bus0.pred_taken), 32'h0);
      chk("rst_target", bus0.pred_target, 32'h44);
      chk("rst_index", 32'(bus0.pred_index), 32'h0);
      chk("rst_lookups", bus0.stat_lookups, 32'h0);
      @(negedge CLK);
      nRST = 1'b1;

      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         bus0.lookup_en      = vecs[i].lkEn;
         bus0.lookup_pc      = vecs[i].lkPc;
         bus0.upd_en         = vecs[i].upEn;
         bus0.upd_index      = vecs[i].upPc[5:2];
         bus0.upd_pc         = vecs[i].upPc;
         bus0.upd_taken      = vecs[i].upTk;
         bus0.upd_target     = vecs[i].upTgt;
         bus0.upd_mispredict = vecs[i].upMis;
         bus0.flush          = vecs[i].fl;
         #1;
         chk($sformatf("v%0d_taken", i), 32'(bus0.pred_taken), 32'(vecs[i].expTk));
         chk($sformatf("v%0d_target", i), bus0.pred_target, vecs[i].expTgt);
         chk($sformatf("v%0d_index", i), 32'(bus0.pred_index), 32'(vecs[i].expIdx));
         chk($sformatf("v%0d_lookups", i), bus0.stat_lookups, vecs[i].expLk);
         chk($sformatf("v%0d_mispred", i), bus0.stat_mispred, vecs[i].expMp);
      end
      @(negedge CLK);
      idle0();

      // gshare: commit T,T,N,T at index 0 (pc 0x80); history walks 0,1,3,6 -> D
      ghrExp = '{4'h0, 4'h1, 4'h3, 4'h6};
      tkSeq  = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         bus1.lookup_en  = 1;
         bus1.lookup_pc  = 32'h40;
         bus1.upd_en     = 1;
         bus1.upd_index  = 4'h0;
         bus1.upd_pc     = 32'h80;
         bus1.upd_taken  = tkSeq[k];
         bus1.upd_target = 32'h500;
         #1;
         chk($sformatf("gs%0d_index", k), 32'(bus1.pred_index), 32'(ghrExp[k]));
      end
      @(negedge CLK);
      bus1.upd_en = 0;
      #1;
      chk("gs_index_D", 32'(bus1.pred_index), 32'hD);
      chk("gs_miss_taken", 32'(bus1.pred_taken), 32'h0);
      chk("gs_miss_target", bus1.pred_target, 32'h44);
      // 0xB4 folds with history D onto index 0 and carries tag of 0x80
      bus1.lookup_pc = 32'hB4;
      #1;
      chk("gs_hit_taken", 32'(bus1.pred_taken), 32'h1);
      chk("gs_hit_target", bus1.pred_target, 32'h500);
      chk("gs_hit_index", 32'(bus1.pred_index), 32'h0);

      // Asynchronous reset landing mid-cycle with an update pending
      @(posedge CLK);
      #3;
      bus1.upd_en = 1; bus1.upd_taken = 1; bus1.upd_index = 4'h0; bus1.upd_pc = 32'hB4;
      bus0.lookup_en = 1; bus0.lookup_pc = 32'h440;
      nRST = 1'b0;
      #1;
      chk("ar_taken", 32'(bus1.pred_taken), 32'h0);
      chk("ar_target", bus1.pred_target, 32'hB8);
      chk("ar_index", 32'(bus1.pred_index), 32'hD);
      chk("ar_lookups", bus1.stat_lookups, 32'h0);
      chk("ar_mispred0", bus0.stat_mispred, 32'h0);
      chk("ar_dut0_taken", 32'(bus0.pred_taken), 32'h0);
      bus1.upd_en = 0;
      @(negedge CLK);
      nRST = 1'b1;
      #1;
      chk("post_taken", 32'(bus1.pred_taken), 32'h0);
      chk("post_index", 32'(bus1.pred_index), 32'hD);
      chk("post_dut0_target", bus0.pred_target, 32'h444);
      @(negedge CLK);
      #1;
      chk("post_dut1_lookups", bus1.stat_lookups, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
